// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b word/line types and write-back buffer state encoding
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;
  typedef logic [11:0]  lc3b_line_tag;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_FILL  = 2'd1,
    WB_DRAIN = 2'd2,
    WB_RESP  = 2'd3
  } wb_state_t;

endpackage

// File: rtl/comparator.sv
// rtl/comparator.sv - equality comparator
module comparator #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq
);

  assign eq = (a == b);

endmodule

// File: rtl/l2_writeback_buffer_control.sv
// rtl/l2_writeback_buffer_control.sv - victim buffer FSM: Moore strobes and datapath load enables
module l2_writeback_buffer_control
  import lc3b_types::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_mem_read,
  input  logic i_mem_write,
  input  logic i_buf_valid,
  input  logic i_match,
  input  logic i_pmem_resp,
  output logic o_mem_resp,
  output logic o_pmem_read,
  output logic o_pmem_write,
  output logic o_load_buf,
  output logic o_load_rdata,
  output logic o_rdata_sel,
  output logic o_clear_valid
);

  wb_state_t r_state;
  wb_state_t w_next;
  logic      r_mem_resp;
  logic      r_pmem_read;
  logic      r_pmem_write;

  // Read takes priority over write, so a simultaneous read+write behaves as a read.
  always_comb begin
    w_next        = r_state;
    o_load_buf    = 1'b0;
    o_load_rdata  = 1'b0;
    o_rdata_sel   = 1'b0;
    o_clear_valid = 1'b0;
    unique case (r_state)
      WB_IDLE: begin
        if (i_mem_read && i_match) begin
          o_load_rdata = 1'b1;
          w_next       = WB_RESP;
        end else if (i_mem_read) begin
          w_next = WB_FILL;
        end else if (i_mem_write && (!i_buf_valid || i_match)) begin
          o_load_buf = 1'b1;
          w_next     = WB_RESP;
        end else if (i_mem_write || i_buf_valid) begin
          w_next = WB_DRAIN;
        end
      end
      WB_FILL: begin
        if (i_pmem_resp) begin
          o_load_rdata = 1'b1;
          o_rdata_sel  = 1'b1;
          w_next       = WB_RESP;
        end
      end
      WB_DRAIN: begin
        if (i_pmem_resp) begin
          o_clear_valid = 1'b1;
          w_next        = WB_IDLE;
        end
      end
      WB_RESP: w_next = WB_IDLE;
      default: w_next = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= WB_IDLE;
      r_mem_resp   <= 1'b0;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_mem_resp   <= (w_next == WB_RESP);
      r_pmem_read  <= (w_next == WB_FILL);
      r_pmem_write <= (w_next == WB_DRAIN);
    end
  end

  assign o_mem_resp   = r_mem_resp;
  assign o_pmem_read  = r_pmem_read;
  assign o_pmem_write = r_pmem_write;

endmodule

// File: rtl/mux2.sv
// rtl/mux2.sv - two-input multiplexer, sel=1 picks b
module mux2 #(
  parameter int WIDTH = 128
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] f
);

  assign f = sel ? b : a;

endmodule

// File: rtl/l2_writeback_buffer.sv
// rtl/l2_writeback_buffer.sv - single-entry L2 victim buffer: datapath registers, tag match, control
module l2_writeback_buffer
  import lc3b_types::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      mem_read,
  input  logic      mem_write,
  input  lc3b_word  mem_address,
  input  lc3b_line  mem_wdata,
  output lc3b_line  mem_rdata,
  output logic      mem_resp,
  output logic      pmem_read,
  output logic      pmem_write,
  output lc3b_word  pmem_address,
  output lc3b_line  pmem_wdata,
  input  lc3b_line  pmem_rdata,
  input  logic      pmem_resp,
  output logic      buf_valid
);

  logic         r_buf_valid;
  lc3b_line_tag r_buf_tag;
  lc3b_line     r_buf_data;
  lc3b_line     r_mem_rdata;

  logic         w_tag_eq;
  logic         w_match;
  logic         w_load_buf;
  logic         w_load_rdata;
  logic         w_rdata_sel;
  logic         w_clear_valid;
  lc3b_line     w_rdata_next;
  logic         w_unused;

  assign w_unused = ^mem_address[3:0];

  comparator #(.WIDTH(12)) u_tag_cmp (
    .a  (mem_address[15:4]),
    .b  (r_buf_tag),
    .eq (w_tag_eq)
  );

  assign w_match = r_buf_valid && w_tag_eq;

  mux2 #(.WIDTH(128)) u_rdata_mux (
    .sel (w_rdata_sel),
    .a   (r_buf_data),
    .b   (pmem_rdata),
    .f   (w_rdata_next)
  );

  l2_writeback_buffer_control u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .i_mem_read    (mem_read),
    .i_mem_write   (mem_write),
    .i_buf_valid   (r_buf_valid),
    .i_match       (w_match),
    .i_pmem_resp   (pmem_resp),
    .o_mem_resp    (mem_resp),
    .o_pmem_read   (pmem_read),
    .o_pmem_write  (pmem_write),
    .o_load_buf    (w_load_buf),
    .o_load_rdata  (w_load_rdata),
    .o_rdata_sel   (w_rdata_sel),
    .o_clear_valid (w_clear_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_valid <= 1'b0;
      r_buf_tag   <= '0;
      r_buf_data  <= '0;
      r_mem_rdata <= '0;
    end else begin
      if (w_load_buf) begin
        r_buf_valid <= 1'b1;
        r_buf_tag   <= mem_address[15:4];
        r_buf_data  <= mem_wdata;
      end else if (w_clear_valid) begin
        r_buf_valid <= 1'b0;
      end
      if (w_load_rdata) begin
        r_mem_rdata <= w_rdata_next;
      end
    end
  end

  // The L2 holds mem_address for the whole fill, so the fill address can be taken combinationally.
  always_comb begin
    pmem_address = '0;
    if (pmem_read) begin
      pmem_address = {mem_address[15:4], 4'h0};
    end else if (pmem_write) begin
      pmem_address = {r_buf_tag, 4'h0};
    end
  end

  assign pmem_wdata = r_buf_data;
  assign mem_rdata  = r_mem_rdata;
  assign buf_valid  = r_buf_valid;

endmodule

// File: tb/tb_l2_writeback_buffer.sv
// tb/tb_l2_writeback_buffer.sv - directed self-checking bench for l2_writeback_buffer
module tb_l2_writeback_buffer;

  logic         clk;
  logic         rst;
  logic         mem_read;
  logic         mem_write;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic         buf_valid;

  int n_vec;
  int n_err;

  localparam logic [127:0] DATA_A = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
  localparam logic [127:0] DATA_B = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
  localparam logic [127:0] DATA_C = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
  localparam logic [127:0] DATA_D = 128'hD0D1D2D3_D4D5D6D7_D8D9DADB_DCDDDEDF;
  localparam logic [127:0] DATA_E = 128'hE0E1E2E3_E4E5E6E7_E8E9EAEB_ECEDEEEF;
  localparam logic [127:0] DATA_F = 128'hF0F1F2F3_F4F5F6F7_F8F9FAFB_FCFDFEFF;

  l2_writeback_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .buf_valid    (buf_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst         = 1'b1;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = 16'h0;
    mem_wdata   = '0;
    pmem_rdata  = '0;
    pmem_resp   = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    chk("rst_mem_resp",   128'(mem_resp), 128'd0);
    chk("rst_pmem_read",  128'(pmem_read), 128'd0);
    chk("rst_pmem_write", 128'(pmem_write), 128'd0);
    chk("rst_pmem_addr",  128'(pmem_address), 128'd0);
    chk("rst_buf_valid",  128'(buf_valid), 128'd0);
    chk("rst_mem_rdata",  mem_rdata, 128'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_strobes", 128'({pmem_read, pmem_write, mem_resp}), 128'd0);
    end

    // Write into empty buffer, then watch it drain on its own.
    mem_write = 1'b1; mem_address = 16'h1230; mem_wdata = DATA_A;
    step();
    chk("wr_a_resp",  128'(mem_resp), 128'd1);
    chk("wr_a_valid", 128'(buf_valid), 128'd1);
    mem_write = 1'b0;
    step();
    chk("wr_a_idle", 128'({mem_resp, pmem_write}), 128'd0);
    step();
    chk("drain_a_wr",    128'(pmem_write), 128'd1);
    chk("drain_a_addr",  128'(pmem_address), 128'h1230);
    chk("drain_a_wdata", pmem_wdata, DATA_A);
    step();
    chk("drain_a_hold",  128'({pmem_write, pmem_address}), 128'h1_1230);
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    chk("drain_a_done_valid", 128'(buf_valid), 128'd0);
    chk("drain_a_done_wr",    128'(pmem_write), 128'd0);
    chk("drain_a_done_addr",  128'(pmem_address), 128'd0);

    // Buffer B at 0x4560, then read hit on the same line.
    mem_write = 1'b1; mem_address = 16'h4560; mem_wdata = DATA_B;
    step();
    chk("wr_b_resp", 128'(mem_resp), 128'd1);
    mem_write = 1'b0; mem_read = 1'b1; mem_address = 16'h4568;
    step();
    chk("hit_idle", 128'({mem_resp, pmem_read}), 128'd0);
    step();
    chk("hit_resp",  128'(mem_resp), 128'd1);
    chk("hit_rdata", mem_rdata, DATA_B);
    chk("hit_no_pmem", 128'({pmem_read, pmem_write}), 128'd0);

    // Read miss to 0x7770 goes to memory ahead of the buffered line.
    mem_address = 16'h7770;
    step();
    step();
    chk("miss_rd",   128'(pmem_read), 128'd1);
    chk("miss_addr", 128'(pmem_address), 128'h7770);
    chk("miss_no_wr", 128'(pmem_write), 128'd0);
    step();
    chk("miss_hold", 128'({pmem_read, mem_resp}), 128'd2);
    pmem_rdata = DATA_F; pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    chk("miss_resp",  128'(mem_resp), 128'd1);
    chk("miss_rdata", mem_rdata, DATA_F);
    chk("miss_rd_off", 128'(pmem_read), 128'd0);
    chk("miss_b_kept", 128'(buf_valid), 128'd1);

    // Conflicting write 0x8880/C forces B out first.
    mem_read = 1'b0; mem_write = 1'b1; mem_address = 16'h8880; mem_wdata = DATA_C;
    step();
    step();
    chk("conf_drain_wr",    128'(pmem_write), 128'd1);
    chk("conf_drain_addr",  128'(pmem_address), 128'h4560);
    chk("conf_drain_wdata", pmem_wdata, DATA_B);
    chk("conf_no_resp",     128'(mem_resp), 128'd0);
    step();
    chk("conf_drain_hold", pmem_wdata, DATA_B);
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    chk("conf_idle", 128'({mem_resp, pmem_write, buf_valid}), 128'd0);
    step();
    chk("conf_resp",  128'(mem_resp), 128'd1);
    chk("conf_valid", 128'(buf_valid), 128'd1);
    mem_write = 1'b0;
    step();
    step();
    chk("c_drain_addr",  128'(pmem_address), 128'h8880);
    chk("c_drain_wdata", pmem_wdata, DATA_C);

    // Reset in the middle of a drain abandons the line.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_drain_valid", 128'(buf_valid), 128'd0);
    chk("rst_drain_wr",    128'(pmem_write), 128'd0);
    chk("rst_drain_addr",  128'(pmem_address), 128'd0);
    step();
    chk("rst_drain_stay_idle", 128'({pmem_write, pmem_read, mem_resp}), 128'd0);

    // Same-line overwrite: the last write wins.
    mem_write = 1'b1; mem_address = 16'h2220; mem_wdata = DATA_D;
    step();
    chk("wr_d_resp", 128'(mem_resp), 128'd1);
    mem_address = 16'h2228; mem_wdata = DATA_E;
    step();
    step();
    chk("wr_e_resp", 128'(mem_resp), 128'd1);
    mem_write = 1'b0;
    step();
    step();
    chk("e_drain_addr",  128'(pmem_address), 128'h2220);
    chk("e_drain_wdata", pmem_wdata, DATA_E);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
